led_pio_blink: RTL



---
 rtl/led_pio_blink.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/led_pio_blink.sv
// led_pio_blink
// Avalon-MM slave output PIO driving WIDTH LED lines. Adds atomic set/clear
// writes on top of the plain DATA register, a per-channel blink enable and a
// shared blink phase generator with a programmable half-period.
//
// Register map (word addresses):
//   0 DATA        RW  WIDTH bits
//   1 BLINK_EN    RW  WIDTH bits
//   2 HALF_PERIOD RW  PERIOD_W bits, in clk cycles (0 stops blinking)
//   3 STATUS      RO  bit0 = current blink phase
//   4 OUTSET      WO  DATA |= writedata
//   5 OUTCLEAR    WO  DATA &= ~writedata
//   6, 7          reserved, read 0
//
// DEFAULT_HALF_PERIOD is reduced modulo 2**PERIOD_W when it is loaded into
// the register. The library default of 25000000 needs PERIOD_W >= 25 to be
// held exactly; with PERIOD_W = 24 it loads as 8222784.
module led_pio_blink #(
  parameter int unsigned       WIDTH               = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE         = '0,
  parameter int unsigned       PERIOD_W            = 24,
  parameter int unsigned       DEFAULT_HALF_PERIOD = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  // Word addresses of the register map.
  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN    = 3'd1;
  localparam logic [2:0] ADDR_HALF_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS      = 3'd3;
  localparam logic [2:0] ADDR_OUTSET      = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

  localparam logic [PERIOD_W-1:0] HALF_PERIOD_RST = PERIOD_W'(DEFAULT_HALF_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE             = PERIOD_W'(1);

  // Architectural registers.
  logic [WIDTH-1:0]    data_q,        data_d;
  logic [WIDTH-1:0]    blink_en_q,    blink_en_d;
  logic [PERIOD_W-1:0] half_period_q, half_period_d;

  // Blink generator state.
  logic [PERIOD_W-1:0] cnt_q,         cnt_d;
  logic                phase_q,       phase_d;

  // Registered LED drive.
  logic [WIDTH-1:0]    out_q,         out_d;

  // Bus decode.
  logic                wr;
  logic                hp_wr;
  logic [WIDTH-1:0]    wdata_w;
  logic [PERIOD_W-1:0] wdata_p;
  logic                unused_writedata;

  assign wr      = chipselect & ~write_n;
  assign hp_wr   = wr && (address == ADDR_HALF_PERIOD);
  assign wdata_w = writedata[WIDTH-1:0];
  assign wdata_p = writedata[PERIOD_W-1:0];

  // Bits above WIDTH / PERIOD_W have no destination; fold them here so the
  // bus stays fully connected without feeding any logic.
  assign unused_writedata = ^writedata;

  // Register write decode: DATA, BLINK_EN, HALF_PERIOD and the set/clear aliases.
  always_comb begin
    // NOTE: every *_d is given its hold value before the case so each path
    // assigns it and no latch is inferred.
    data_d        = data_q;
    blink_en_d    = blink_en_q;
    half_period_d = half_period_q;
    if (wr) begin
      case (address)
        ADDR_DATA:        data_d        = wdata_w;
        ADDR_BLINK_EN:    blink_en_d    = wdata_w;
        ADDR_HALF_PERIOD: half_period_d = wdata_p;
        ADDR_OUTSET:      data_d        = data_q | wdata_w;
        ADDR_OUTCLEAR:    data_d        = data_q & ~wdata_w;
        default:          ; // STATUS and reserved words ignore writes
      endcase
    end
  end

  // Blink phase generator: cnt runs 0..HALF_PERIOD-1, phase flips on each wrap.
  // A HALF_PERIOD write restarts the generator so a lowered period can never
  // leave cnt above the new terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (hp_wr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == half_period_q - ONE) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + ONE;
    end
  end

  // LED drive: blinking channels are dark in phase 0 and show DATA in phase 1.
  // Built from pre-edge register values, so a write reaches the pins one
  // cycle after its own edge.
  always_comb begin
    out_d = data_q & (~blink_en_q | {WIDTH{phase_q}});
  end

  // Zero-latency read mux; not gated by chipselect and free of side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:        readdata[WIDTH-1:0]    = data_q;
      ADDR_BLINK_EN:    readdata[WIDTH-1:0]    = blink_en_q;
      ADDR_HALF_PERIOD: readdata[PERIOD_W-1:0] = half_period_q;
      ADDR_STATUS:      readdata[0]            = phase_q;
      default:          readdata               = '0;
    endcase
  end

  // State registers with synchronous active-low reset; reset wins over any
  // write presented on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!reset_n) begin
      data_q        <= RESET_VALUE;
      blink_en_q    <= '0;
      half_period_q <= HALF_PERIOD_RST;
      cnt_q         <= '0;
      phase_q       <= 1'b0;
      out_q         <= RESET_VALUE;
    end else begin
      data_q        <= data_d;
      blink_en_q    <= blink_en_d;
      half_period_q <= half_period_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      out_q         <= out_d;
    end
  end

  assign out_port = out_q;

endmodule
